// File: rtl/softex_pkg.sv
// Shared types for the softex x slicer: control/flag structs and FSM state encoding.
package softex_pkg;

    localparam int unsigned BUF_CNT_WIDTH = 8;
    localparam int unsigned X_NUM_SLICES  = 4;
    localparam int unsigned X_IDX_W       = $clog2(X_NUM_SLICES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } x_slicer_state_t;

    typedef struct packed {
        logic                     start;
        logic [BUF_CNT_WIDTH-1:0] num_beats;
    } x_slicer_ctrl_t;

    typedef struct packed {
        logic               busy;
        logic               done;
        logic [X_IDX_W-1:0] slice_idx;
    } x_slicer_flags_t;

endpackage

// File: rtl/softex_x_slicer_next_idx.sv
// Priority search for the next slice above the current index with a nonzero strobe.
module softex_x_slicer_next_idx #(
    parameter int unsigned NUM_SLICES = 4,
    parameter int unsigned SSTRB_W    = 4,
    parameter int unsigned IDX_W      = $clog2(NUM_SLICES)
) (
    input  logic [NUM_SLICES-1:0][SSTRB_W-1:0] i_strb,
    input  logic [IDX_W-1:0]                   i_idx,
    output logic [IDX_W-1:0]                   o_next_idx,
    output logic                               o_last
);

    // Scan downwards so the lowest qualifying index wins.
    always_comb begin
        o_next_idx = '0;
        o_last     = 1'b1;
        for (int i = NUM_SLICES - 1; i >= 0; i--) begin
            if (i > int'(i_idx) && |i_strb[i]) begin
                o_next_idx = IDX_W'(i);
                o_last     = 1'b0;
            end
        end
    end

endmodule

// File: rtl/softex_x_slicer.sv
// Serializes wide x beats into strobe-qualified slices and counts beats per job.
// Optional SOFTEX_X_SLICER_OUT_REG_EN adds a 1-entry output register (latency 1).
module softex_x_slicer
    import softex_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_SLICES  = X_NUM_SLICES,
    parameter int unsigned SLICE_WIDTH = DATA_WIDTH / NUM_SLICES,
    parameter int unsigned CNT_WIDTH   = BUF_CNT_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  x_slicer_ctrl_t            ctrl_i,
    output x_slicer_flags_t           flags_o,
    input  logic                      buffer_valid_i,
    output logic                      buffer_ready_o,
    input  logic [DATA_WIDTH-1:0]     buffer_data_i,
    input  logic [DATA_WIDTH/8-1:0]   buffer_strb_i,
    output logic                      slice_valid_o,
    input  logic                      slice_ready_i,
    output logic [SLICE_WIDTH-1:0]    slice_data_o,
    output logic [SLICE_WIDTH/8-1:0]  slice_strb_o
);

    localparam int unsigned SSTRB_W = SLICE_WIDTH / 8;
    localparam int unsigned IDX_W   = $clog2(NUM_SLICES);

    x_slicer_state_t                       r_state;
    logic [CNT_WIDTH-1:0]                  r_cnt, r_num;
    logic [IDX_W-1:0]                      r_idx, w_next_idx;
    logic                                  w_last, w_cur_nz, w_run, w_sel_valid, w_sel_ready;
    logic                                  w_adv, w_in_hs, w_cnt_hit;
    logic [NUM_SLICES-1:0][SLICE_WIDTH-1:0] w_data_sl;
    logic [NUM_SLICES-1:0][SSTRB_W-1:0]     w_strb_sl;

    assign w_data_sl = buffer_data_i;
    assign w_strb_sl = buffer_strb_i;
    assign w_cur_nz  = |w_strb_sl[r_idx];

    softex_x_slicer_next_idx #(
        .NUM_SLICES (NUM_SLICES),
        .SSTRB_W    (SSTRB_W),
        .IDX_W      (IDX_W)
    ) u_next_idx (
        .i_strb     (w_strb_sl),
        .i_idx      (r_idx),
        .o_next_idx (w_next_idx),
        .o_last     (w_last)
    );

`ifdef SOFTEX_X_SLICER_OUT_REG_EN
    logic                   r_fin, r_ov;
    logic [SLICE_WIDTH-1:0] r_od;
    logic [SSTRB_W-1:0]     r_os;

    // After the last beat is taken, selection stops until the register drains.
    assign w_run       = (r_state == RUN) & ~clear_i & ~r_fin;
    assign w_sel_ready = ~r_ov | slice_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ov <= 1'b0;
            r_od <= '0;
            r_os <= '0;
        end else if (clear_i) begin
            r_ov <= 1'b0;
        end else if (w_sel_ready) begin
            r_ov <= w_sel_valid;
            r_od <= w_data_sl[r_idx];
            r_os <= w_strb_sl[r_idx];
        end
    end

    assign slice_valid_o = r_ov & ~clear_i;
    assign slice_data_o  = r_od;
    assign slice_strb_o  = r_os;
`else
    assign w_run       = (r_state == RUN) & ~clear_i;
    assign w_sel_ready = slice_ready_i;

    assign slice_valid_o = w_sel_valid;
    assign slice_data_o  = w_data_sl[r_idx];
    assign slice_strb_o  = w_strb_sl[r_idx];
`endif

    // Empty slices advance without waiting on the consumer.
    assign w_sel_valid    = w_run & buffer_valid_i & w_cur_nz;
    assign w_adv          = w_run & buffer_valid_i & (~w_cur_nz | w_sel_ready);
    assign w_in_hs        = w_adv & w_last;
    assign buffer_ready_o = w_in_hs;
    assign w_cnt_hit      = CNT_WIDTH'(r_cnt + 1'b1) == r_num;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_num   <= '0;
            r_idx   <= '0;
`ifdef SOFTEX_X_SLICER_OUT_REG_EN
            r_fin   <= 1'b0;
`endif
        end else if (clear_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
`ifdef SOFTEX_X_SLICER_OUT_REG_EN
            r_fin   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (ctrl_i.start) begin
                        r_num   <= CNT_WIDTH'(ctrl_i.num_beats);
                        r_state <= (ctrl_i.num_beats == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (w_in_hs) begin
                        r_idx <= '0;
                        if (w_cnt_hit) begin
                            r_cnt <= '0;
`ifdef SOFTEX_X_SLICER_OUT_REG_EN
                            r_fin <= 1'b1;
`else
                            r_state <= DONE;
`endif
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (w_adv) begin
                        r_idx <= w_next_idx;
                    end
`ifdef SOFTEX_X_SLICER_OUT_REG_EN
                    if (r_fin && !r_ov) begin
                        r_fin   <= 1'b0;
                        r_state <= DONE;
                    end
`endif
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign flags_o.busy      = (r_state != IDLE);
    assign flags_o.done      = (r_state == DONE);
    assign flags_o.slice_idx = X_IDX_W'(r_idx);

endmodule

// File: tb/tb_softex_x_slicer.sv
// Directed bench for softex_x_slicer (128-bit beats, 4 x 32-bit slices, default build).
module tb_softex_x_slicer;
    import softex_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clear;
    x_slicer_ctrl_t  ctrl;
    x_slicer_flags_t flags;
    logic            bv, br, sv, sr;
    logic [127:0]    bd;
    logic [15:0]     bs;
    logic [31:0]     sd;
    logic [3:0]      ss;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    softex_x_slicer #(
        .DATA_WIDTH (128),
        .NUM_SLICES (4)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clear_i        (clear),
        .ctrl_i         (ctrl),
        .flags_o        (flags),
        .buffer_valid_i (bv),
        .buffer_ready_o (br),
        .buffer_data_i  (bd),
        .buffer_strb_i  (bs),
        .slice_valid_o  (sv),
        .slice_ready_i  (sr),
        .slice_data_o   (sd),
        .slice_strb_o   (ss)
    );

    function automatic logic [31:0] exp_slice(input int b, input int k);
        return 32'hC0DE_0000 | 32'(b << 8) | 32'(k);
    endfunction

    function automatic logic [127:0] mk_beat(input int b);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[k*32 +: 32] = exp_slice(b, k);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; ctrl = '0; ctrl.start = 1'b1; ctrl.num_beats = 8'd3;
        bv = 1'b1; bd = mk_beat(0); bs = 16'hFFFF; sr = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_chk++;
            if (sv !== 1'b0 || br !== 1'b0 || flags !== '0) begin
                n_fail++;
                $display("FAIL reset: sv=%b br=%b flags=%h, required 0/0/0", sv, br, flags);
            end
        end
        ctrl = '0; bv = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_strobe();
        ctrl.start = 1'b1; ctrl.num_beats = 8'd2;
        bv = 1'b1; bd = mk_beat(0); bs = 16'hFFFF; sr = 1'b1;
        #1;
        n_chk++;
        if (sv !== 1'b0 || br !== 1'b0) begin
            n_fail++; $display("FAIL full_idle: sv=%b br=%b, required 0/0", sv, br);
        end
        tick();
        ctrl.start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bd = mk_beat(b);
            for (int k = 0; k < 4; k++) begin
                #1;
                n_chk++;
                if (sv !== 1'b1 || sd !== exp_slice(b, k) || ss !== 4'hF ||
                    flags.slice_idx !== 2'(k) || br !== (k == 3)) begin
                    n_fail++;
                    $display("FAIL full_slice b%0d k%0d: sv=%b sd=%h ss=%h idx=%0d br=%b, required 1/%h/f/%0d/%b",
                             b, k, sv, sd, ss, flags.slice_idx, br, exp_slice(b, k), k, k == 3);
                end
                tick();
            end
        end
        bv = 1'b0;
        #1;
        n_chk++;
        if (flags.done !== 1'b1 || flags.busy !== 1'b1) begin
            n_fail++; $display("FAIL full_done: done=%b busy=%b, required 1/1", flags.done, flags.busy);
        end
        tick();
        n_chk++;
        if (flags.done !== 1'b0 || flags.busy !== 1'b0) begin
            n_fail++; $display("FAIL full_idle_after: done=%b busy=%b, required 0/0", flags.done, flags.busy);
        end
    endtask

    task automatic test_sparse_strobe();
        ctrl.start = 1'b1; ctrl.num_beats = 8'd1;
        bv = 1'b1; bd = mk_beat(5); bs = 16'h0F0F; sr = 1'b1;
        tick();
        ctrl.start = 1'b0;
        #1;
        n_chk++;
        if (sv !== 1'b1 || sd !== exp_slice(5, 0) || br !== 1'b0) begin
            n_fail++; $display("FAIL sparse_s0: sv=%b sd=%h br=%b, required 1/%h/0", sv, sd, br, exp_slice(5, 0));
        end
        tick();
        n_chk++;
        if (sv !== 1'b1 || sd !== exp_slice(5, 2) || br !== 1'b1 || flags.slice_idx !== 2'd2) begin
            n_fail++; $display("FAIL sparse_s2: sv=%b sd=%h br=%b idx=%0d, required 1/%h/1/2",
                               sv, sd, br, flags.slice_idx, exp_slice(5, 2));
        end
        tick();
        bv = 1'b0;
        #1;
        n_chk++;
        if (flags.done !== 1'b1) begin
            n_fail++; $display("FAIL sparse_done: done=%b, required 1", flags.done);
        end
        tick();
    endtask

    task automatic test_zero_strobe();
        ctrl.start = 1'b1; ctrl.num_beats = 8'd1;
        bv = 1'b1; bd = mk_beat(6); bs = 16'h0000; sr = 1'b1;
        tick();
        ctrl.start = 1'b0;
        #1;
        n_chk++;
        if (sv !== 1'b0 || br !== 1'b1) begin
            n_fail++; $display("FAIL zero_strb: sv=%b br=%b, required 0/1", sv, br);
        end
        tick();
        bv = 1'b0;
        #1;
        n_chk++;
        if (flags.done !== 1'b1 || sv !== 1'b0) begin
            n_fail++; $display("FAIL zero_done: done=%b sv=%b, required 1/0", flags.done, sv);
        end
        tick();
    endtask

    task automatic test_stall();
        int          b, got;
        bit          seen_done, prev_stall, hs;
        logic [31:0] prev_data;
        ctrl.start = 1'b1; ctrl.num_beats = 8'd2;
        b = 0; bv = 1'b1; bd = mk_beat(10); bs = 16'hFFFF; sr = 1'b0;
        got = 0; seen_done = 1'b0; prev_stall = 1'b0; prev_data = '0;
        tick();
        ctrl.start = 1'b0;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            sr = (c % 4 == 0) || (c % 4 == 3);
            #1;
            if (flags.done) seen_done = 1'b1;
            if (prev_stall) begin
                n_chk++;
                if (sv !== 1'b1 || sd !== prev_data) begin
                    n_fail++; $display("FAIL stall_hold c%0d: sv=%b sd=%h, required 1/%h", c, sv, sd, prev_data);
                end
            end
            if (sv && sr) begin
                n_chk++;
                if (sd !== exp_slice(10 + got / 4, got % 4)) begin
                    n_fail++; $display("FAIL stall_order #%0d: sd=%h, required %h", got, sd, exp_slice(10 + got / 4, got % 4));
                end
                got++;
            end
            prev_stall = sv && !sr;
            prev_data  = sd;
            hs = br;
            tick();
            if (hs) begin
                b++;
                bd = mk_beat(10 + b);
            end
        end
        bv = 1'b0;
        n_chk++;
        if (got != 8 || !seen_done) begin
            n_fail++; $display("FAIL stall_count: slices=%0d done_seen=%b, required 8/1", got, seen_done);
        end
        tick();
    endtask

    task automatic test_zero_beats();
        ctrl.start = 1'b1; ctrl.num_beats = 8'd0;
        bv = 1'b1; bd = mk_beat(20); bs = 16'hFFFF; sr = 1'b1;
        tick();
        ctrl.start = 1'b0;
        #1;
        n_chk++;
        if (flags.done !== 1'b1 || br !== 1'b0 || sv !== 1'b0) begin
            n_fail++; $display("FAIL zero_beats: done=%b br=%b sv=%b, required 1/0/0", flags.done, br, sv);
        end
        tick();
        n_chk++;
        if (flags.busy !== 1'b0 || br !== 1'b0) begin
            n_fail++; $display("FAIL zero_beats_idle: busy=%b br=%b, required 0/0", flags.busy, br);
        end
        bv = 1'b0;
    endtask

    task automatic test_clear();
        ctrl.start = 1'b1; ctrl.num_beats = 8'd1;
        bv = 1'b1; bd = mk_beat(30); bs = 16'hFFFF; sr = 1'b1;
        tick();
        ctrl.start = 1'b0;
        tick();
        tick();
        #1;
        n_chk++;
        if (flags.slice_idx !== 2'd2 || sd !== exp_slice(30, 2)) begin
            n_fail++; $display("FAIL clear_pre: idx=%0d sd=%h, required 2/%h", flags.slice_idx, sd, exp_slice(30, 2));
        end
        clear = 1'b1;
        #1;
        n_chk++;
        if (sv !== 1'b0 || br !== 1'b0) begin
            n_fail++; $display("FAIL clear_out: sv=%b br=%b, required 0/0", sv, br);
        end
        tick();
        clear = 1'b0;
        #1;
        n_chk++;
        if (flags.busy !== 1'b0 || flags.done !== 1'b0 || flags.slice_idx !== 2'd0 || sv !== 1'b0) begin
            n_fail++; $display("FAIL clear_post: busy=%b done=%b idx=%0d sv=%b, required 0/0/0/0",
                               flags.busy, flags.done, flags.slice_idx, sv);
        end
        tick();
        n_chk++;
        if (flags.done !== 1'b0) begin
            n_fail++; $display("FAIL clear_nodone: done=%b, required 0", flags.done);
        end
        ctrl.start = 1'b1; ctrl.num_beats = 8'd1; bd = mk_beat(31);
        tick();
        ctrl.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_chk++;
            if (sv !== 1'b1 || sd !== exp_slice(31, k) || br !== (k == 3)) begin
                n_fail++; $display("FAIL clear_restart k%0d: sv=%b sd=%h br=%b, required 1/%h/%b",
                                   k, sv, sd, br, exp_slice(31, k), k == 3);
            end
            tick();
        end
        bv = 1'b0;
        #1;
        n_chk++;
        if (flags.done !== 1'b1) begin
            n_fail++; $display("FAIL clear_restart_done: done=%b, required 1", flags.done);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_full_strobe();
        test_sparse_strobe();
        test_zero_strobe();
        test_stall();
        test_zero_beats();
        test_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
